cond_eval_unit: RTL and testbench
=================================

# cond_eval_unit

Parametrised condition-evaluation stage for the execute path. It holds the architectural NZCV flag register with per-flag masked writes. It evaluates the 4-bit condition code of `NCH` instruction slots per request against those flags, including the NV (never) code, and returns the results through a one-deep registered valid/ready stage with a passthrough tag. It sits between the decode/issue logic, which supplies the condition codes, and the writeback/branch logic, which consumes the predicate bits.

## Interface
Parameters:
- `NCH`, 2: number of condition-code channels evaluated per request (1..8).
- `TAG_W`, 4: width of the opaque request tag carried to the output.
- `BYPASS`, 1: 1 = a request accepted in the same cycle as a flag write sees the new flags; 0 = it sees the old flags.
- `FLAG_RST`, 4'b0000: reset value of the flag register, ordered {N,Z,C,V}.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flag_we`  in  1  flag write strobe.
- `flag_mask`  in  4  per-flag write enable {N,Z,C,V}.
- `flag_in`  in  4  new flag values {N,Z,C,V}.
- `flags`  out  4  current registered flags {N,Z,C,V}.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  stage can accept a request.
- `in_cc`  in  4*NCH  condition codes; channel i = `in_cc[4i+3:4i]`.
- `in_tag`  in  TAG_W  request tag.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_cond`  out  NCH  per-channel predicate; bit i belongs to channel i.
- `out_tag`  out  TAG_W  tag of the held result.

## Operation
- Flag register:
  - On a clock edge with `flag_we`=1, `flags <= (flags & ~flag_mask) | (flag_in & flag_mask)`.
  - With `flag_mask`=0, or with `flag_we`=0, the flags are unchanged.
  - Flag updates are independent of the request handshake and never stall.
- Effective flags for evaluation (`eff`):
  - `BYPASS`=1 and `flag_we`=1: the merged value above.
  - Otherwise: `flags`.
- Condition table, with n, z, c, v taken from `eff`:
  - 0 EQ: z
  - 1 NE: !z
  - 2 CS: c
  - 3 CC: !c
  - 4 MI: n
  - 5 PL: !n
  - 6 VS: v
  - 7 VC: !v
  - 8 HI: c & !z
  - 9 LS: !c | z
  - 10 GE: n==v
  - 11 LT: n!=v
  - 12 GT: !z & (n==v)
  - 13 LE: z | (n!=v)
  - 14 AL: 1
  - 15 NV: 0
- Handshake:
  - `in_ready = !out_valid | out_ready` (combinational from `out_ready`).
  - A request is accepted when `in_valid & in_ready`. On acceptance, `out_cond` and `out_tag` are loaded from the evaluation of `in_cc` and `in_tag`, and `out_valid` is set.
  - If `out_valid & out_ready` and no request is accepted, `out_valid` clears. `out_cond` and `out_tag` hold their last values.
  - While `out_valid & !out_ready`, `out_cond` and `out_tag` are frozen. Later flag writes do not alter a held result.
- Reset (asynchronous, any cycle):
  - `flags`=FLAG_RST, `out_valid`=0, `out_cond`=0, `out_tag`=0.
  - Any held or in-flight result is discarded.
  - `in_ready`=1 while in reset.

## Timing
- Latency: a request accepted at edge k presents its result with `out_valid`=1 after edge k.
- Throughput: one request per cycle when `out_ready` is held at 1. Back-to-back accepts give consecutive results with no bubble.
- Flag write visibility:
  - Writing at edge k changes `flags` after edge k.
  - A request accepted at edge k+1 or later always sees the new value.
  - A request accepted at edge k itself sees the new value only when `BYPASS`=1.
- Simultaneous drain and accept: the old result is consumed and the new one is loaded on the same edge, so `out_valid` stays 1.
- `out_cond` bits are registered. There is no combinational path from `in_cc` or flags to `out_cond`.

## Test plan
- Exhaustive table:
  - Stimulus: for all 16 flag values × 16 codes on channel 0 (NCH=2, channel 1 = 14), `out_ready`=1.
  - Required: each result matches the table; channel 1 is always 1; with flags=4'b0110 and cc=8 (HI), `out_cond[0]`=0.
- Masked write:
  - Stimulus: flags=4'b0000; write `flag_in`=4'b1111 with `flag_mask`=4'b1100.
  - Required: `flags`=4'b1100. Then a write with `flag_mask`=0 leaves it at 4'b1100.
- Bypass:
  - Stimulus: flags=0000; in one cycle, write Z=1 (mask 0100) and accept cc=0 (EQ).
  - Required: `out_cond[0]`=1 with `BYPASS`=1; `out_cond[0]`=0 with `BYPASS`=0.
- Backpressure:
  - Stimulus: accept tag 3 (cc=14); hold `out_ready`=0 for 5 cycles while writing the flags.
  - Required: `in_ready`=0; `out_tag`=3 and `out_cond` are stable throughout; the result drains in the first cycle `out_ready`=1.
- Streaming:
  - Stimulus: tags 0..7 accepted back-to-back with `out_ready`=1.
  - Required: `out_valid` stays 1 for 8 cycles; the tags emerge in order 0..7.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 between edges while `out_valid`=1 and flags=1010.
  - Required: immediately `out_valid`=0, `out_cond`=0, `out_tag`=0, `flags`=FLAG_RST.

Source files
------------

// File: rtl/cond_eval_unit.sv
// Condition-evaluation stage: NZCV flag register with masked writes, per-channel
// condition-code evaluation and a one-deep registered valid/ready output stage.
module cond_eval_unit #(
    parameter int unsigned NCH      = 2,
    parameter int unsigned TAG_W    = 4,
    parameter bit          BYPASS   = 1'b1,
    parameter logic [3:0]  FLAG_RST = 4'b0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flag_we,
    input  logic [3:0]         flag_mask,
    input  logic [3:0]         flag_in,
    output logic [3:0]         flags,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4*NCH-1:0]   in_cc,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NCH-1:0]     out_cond,
    output logic [TAG_W-1:0]   out_tag
);

    logic [3:0]       flags_q, flags_d;
    logic [3:0]       flags_merged;
    logic [3:0]       eff;
    logic             out_valid_q, out_valid_d;
    logic [NCH-1:0]   out_cond_q, out_cond_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             accept;
    logic [NCH-1:0]   cond_eval;

    function automatic logic eval_cc(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        logic r;
        {n, z, c, v} = f;
        unique case (cc)
            4'd0:    r = z;
            4'd1:    r = !z;
            4'd2:    r = c;
            4'd3:    r = !c;
            4'd4:    r = n;
            4'd5:    r = !n;
            4'd6:    r = v;
            4'd7:    r = !v;
            4'd8:    r = c & !z;
            4'd9:    r = !c | z;
            4'd10:   r = (n == v);
            4'd11:   r = (n != v);
            4'd12:   r = !z & (n == v);
            4'd13:   r = z | (n != v);
            4'd14:   r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        flags_merged = (flags_q & ~flag_mask) | (flag_in & flag_mask);
        flags_d      = flag_we ? flags_merged : flags_q;
        // With bypass, a request in the write cycle already sees the merged flags.
        eff          = (BYPASS && flag_we) ? flags_merged : flags_q;
    end

    always_comb begin
        cond_eval = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            cond_eval[i] = eval_cc(in_cc[4*i +: 4], eff);
        end
    end

    assign in_ready = !out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_cond_d  = out_cond_q;
        out_tag_d   = out_tag_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_cond_d  = cond_eval;
            out_tag_d   = in_tag;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q     <= FLAG_RST;
            out_valid_q <= 1'b0;
            out_cond_q  <= '0;
            out_tag_q   <= '0;
        end else begin
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            out_cond_q  <= out_cond_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign flags     = flags_q;
    assign out_valid = out_valid_q;
    assign out_cond  = out_cond_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_cond_eval_unit.sv
// Directed bench for cond_eval_unit; a BYPASS=1 and a BYPASS=0 instance share stimulus.
module tb_cond_eval_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flag_we;
    logic [3:0] flag_mask, flag_in;
    logic       in_valid, out_ready;
    logic [7:0] in_cc;
    logic [3:0] in_tag;

    logic [3:0] flags1, flags0;
    logic       in_ready1, in_ready0, out_valid1, out_valid0;
    logic [1:0] out_cond1, out_cond0;
    logic [3:0] out_tag1, out_tag0;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cond_eval_unit #(.NCH(2), .TAG_W(4), .BYPASS(1'b1), .FLAG_RST(4'b0000)) dut1 (
        .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flag_mask(flag_mask),
        .flag_in(flag_in), .flags(flags1), .in_valid(in_valid), .in_ready(in_ready1),
        .in_cc(in_cc), .in_tag(in_tag), .out_valid(out_valid1), .out_ready(out_ready),
        .out_cond(out_cond1), .out_tag(out_tag1)
    );

    cond_eval_unit #(.NCH(2), .TAG_W(4), .BYPASS(1'b0), .FLAG_RST(4'b0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flag_mask(flag_mask),
        .flag_in(flag_in), .flags(flags0), .in_valid(in_valid), .in_ready(in_ready0),
        .in_cc(in_cc), .in_tag(in_tag), .out_valid(out_valid0), .out_ready(out_ready),
        .out_cond(out_cond0), .out_tag(out_tag0)
    );

    // Reference: even codes test a base predicate, odd codes are its complement.
    function automatic logic ref_cc(input logic [3:0] cc, input logic [3:0] f);
        logic base;
        case (cc[3:1])
            3'd0: base = f[2];
            3'd1: base = f[1];
            3'd2: base = f[3];
            3'd3: base = f[0];
            3'd4: base = f[1] & ~f[2];
            3'd5: base = ~(f[3] ^ f[0]);
            3'd6: base = ~f[2] & ~(f[3] ^ f[0]);
            default: base = 1'b1;
        endcase
        return base ^ cc[0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_flags(input logic [3:0] val);
        flag_we = 1'b1; flag_mask = 4'hF; flag_in = val;
        step();
        flag_we = 1'b0; flag_mask = 4'h0; flag_in = 4'h0;
    endtask

    task automatic test_reset();
        vectors++;
        if (flags1 !== 4'b0000 || out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: flags=%b valid=%b ready=%b required 0000 0 1",
                     flags1, out_valid1, in_ready1);
        end
        vectors++;
        if (out_cond1 !== 2'b00 || out_tag1 !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_out: cond=%b tag=%h required 00 0", out_cond1, out_tag1);
        end
    endtask

    task automatic test_table();
        logic exp;
        out_ready = 1'b1;
        for (int f = 0; f < 16; f++) begin
            write_flags(4'(f));
            for (int cc = 0; cc < 16; cc++) begin
                in_valid = 1'b1; in_cc = {4'd14, 4'(cc)}; in_tag = 4'(cc);
                step();
                exp = ref_cc(4'(cc), 4'(f));
                vectors++;
                if (out_valid1 !== 1'b1 || out_cond1 !== {1'b1, exp} || out_tag1 !== 4'(cc)) begin
                    miscompares++;
                    $display("FAIL table f=%b cc=%0d: valid=%b cond=%b tag=%h required 1 %b %h",
                             4'(f), cc, out_valid1, out_cond1, out_tag1, {1'b1, exp}, 4'(cc));
                end
                vectors++;
                if (out_cond0 !== {1'b1, exp}) begin
                    miscompares++;
                    $display("FAIL table_nobyp f=%b cc=%0d: cond=%b required %b",
                             4'(f), cc, out_cond0, {1'b1, exp});
                end
                if (f == 6 && cc == 8) begin
                    vectors++;
                    if (out_cond1[0] !== 1'b0) begin
                        miscompares++;
                        $display("FAIL hi_0110: cond0=%b required 0", out_cond1[0]);
                    end
                end
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_masked_write();
        write_flags(4'b0000);
        flag_we = 1'b1; flag_in = 4'b1111; flag_mask = 4'b1100;
        step();
        vectors++;
        if (flags1 !== 4'b1100) begin
            miscompares++;
            $display("FAIL masked_write: flags=%b required 1100", flags1);
        end
        flag_in = 4'b0000; flag_mask = 4'b0000;
        step();
        flag_we = 1'b0;
        vectors++;
        if (flags1 !== 4'b1100) begin
            miscompares++;
            $display("FAIL zero_mask: flags=%b required 1100", flags1);
        end
    endtask

    task automatic test_bypass();
        write_flags(4'b0000);
        out_ready = 1'b1;
        flag_we = 1'b1; flag_mask = 4'b0100; flag_in = 4'b0100;
        in_valid = 1'b1; in_cc = {4'd14, 4'd0}; in_tag = 4'h1;
        step();
        flag_we = 1'b0; flag_mask = 4'h0; flag_in = 4'h0; in_valid = 1'b0;
        vectors++;
        if (out_cond1[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL bypass1: cond0=%b required 1", out_cond1[0]);
        end
        vectors++;
        if (out_cond0[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL bypass0: cond0=%b required 0", out_cond0[0]);
        end
        vectors++;
        if (flags1 !== 4'b0100 || flags0 !== 4'b0100) begin
            miscompares++;
            $display("FAIL bypass_flags: flags1=%b flags0=%b required 0100", flags1, flags0);
        end
        step();
    endtask

    task automatic test_backpressure();
        // Flags are 0100 here, so channel 1 (EQ) evaluates to 1 at accept.
        out_ready = 1'b0;
        in_valid = 1'b1; in_cc = {4'd0, 4'd14}; in_tag = 4'd3;
        step();
        in_tag = 4'd9; in_cc = {4'd15, 4'd15};
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (in_ready1 !== 1'b0 || out_valid1 !== 1'b1 || out_tag1 !== 4'd3 ||
                out_cond1 !== 2'b11) begin
                miscompares++;
                $display("FAIL hold[%0d]: ready=%b valid=%b tag=%h cond=%b required 0 1 3 11",
                         i, in_ready1, out_valid1, out_tag1, out_cond1);
            end
            flag_we = 1'b1; flag_mask = 4'hF; flag_in = 4'(i * 3);
            step();
        end
        flag_we = 1'b0; flag_mask = 4'h0; in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready1 !== 1'b1 || out_tag1 !== 4'd3 || out_cond1 !== 2'b11) begin
            miscompares++;
            $display("FAIL release: ready=%b tag=%h cond=%b required 1 3 11",
                     in_ready1, out_tag1, out_cond1);
        end
        step();
        vectors++;
        if (out_valid1 !== 1'b0) begin
            miscompares++;
            $display("FAIL drain: valid=%b required 0", out_valid1);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            in_valid = 1'b1; in_cc = {4'd14, 4'd15}; in_tag = 4'(t);
            step();
            vectors++;
            if (out_valid1 !== 1'b1 || out_tag1 !== 4'(t) || out_cond1 !== 2'b10) begin
                miscompares++;
                $display("FAIL stream[%0d]: valid=%b tag=%h cond=%b required 1 %h 10",
                         t, out_valid1, out_tag1, out_cond1, 4'(t));
            end
        end
        in_valid = 1'b0;
        step();
        vectors++;
        if (out_valid1 !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_end: valid=%b required 0", out_valid1);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        flag_we = 1'b1; flag_mask = 4'hF; flag_in = 4'b1010;
        in_valid = 1'b1; in_cc = {4'd14, 4'd14}; in_tag = 4'd5;
        step();
        flag_we = 1'b0; in_valid = 1'b0;
        vectors++;
        if (flags1 !== 4'b1010 || out_valid1 !== 1'b1 || out_tag1 !== 4'd5) begin
            miscompares++;
            $display("FAIL pre_reset: flags=%b valid=%b tag=%h required 1010 1 5",
                     flags1, out_valid1, out_tag1);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid1 !== 1'b0 || out_cond1 !== 2'b00 || out_tag1 !== 4'h0 ||
            flags1 !== 4'b0000 || in_ready1 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid: valid=%b cond=%b tag=%h flags=%b ready=%b required 0 00 0 0000 1",
                     out_valid1, out_cond1, out_tag1, flags1, in_ready1);
        end
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        vectors++;
        if (out_valid1 !== 1'b0 || flags1 !== 4'b0000) begin
            miscompares++;
            $display("FAIL post_reset: valid=%b flags=%b required 0 0000", out_valid1, flags1);
        end
    endtask

    initial begin
        rst_n = 1'b0; flag_we = 1'b0; flag_mask = 4'h0; flag_in = 4'h0;
        in_valid = 1'b0; out_ready = 1'b1; in_cc = 8'h00; in_tag = 4'h0;
        #12;
        test_reset();
        rst_n = 1'b1;
        step();
        test_table();
        test_masked_write();
        test_bypass();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
